// File: rtl/interrupt_controller_if.sv
// Core-side signal bundle for the interrupt controller: raw pins, instruction
// phase strobes from the core, and the request/vector/status returned to it.
interface interrupt_controller_if;
    logic        INT0;
    logic        INT1;
    logic        COMMIT;
    logic        EI;
    logic        DI;
    logic        RETI;
    logic        INT_ACK;
    logic        INT_REQ;
    logic [15:0] VECTOR;
    logic        IE;
    logic [1:0]  IN_SERVICE;

    modport master (
        output INT0, INT1, COMMIT, EI, DI, RETI, INT_ACK,
        input  INT_REQ, VECTOR, IE, IN_SERVICE
    );

    modport slave (
        input  INT0, INT1, COMMIT, EI, DI, RETI, INT_ACK,
        output INT_REQ, VECTOR, IE, IN_SERVICE
    );
endinterface

// File: rtl/interrupt_controller.sv
// Two-line interrupt controller: synchronises pins, latches rising edges,
// prioritises INT0 (non-maskable) over INT1, and tracks a single service level.
module interrupt_controller #(
    parameter logic [15:0] VEC0        = 16'h0004,
    parameter logic [15:0] VEC1        = 16'h0008,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    interrupt_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync0;
    logic [SYNC_STAGES-1:0] r_sync1;
    logic                   r_edge0;
    logic                   r_edge1;
    logic                   r_pend0;
    logic                   r_pend1;
    logic                   r_ie;
    logic                   r_ie_saved;
    logic                   r_int_req;
    logic                   r_sel1;
    logic [15:0]            r_vector;
    logic [1:0]             r_in_service;

    logic w_rise0;
    logic w_rise1;
    logic w_ei;
    logic w_di;
    logic w_reti;
    logic w_ack;
    logic w_ie_next;
    logic w_e0;
    logic w_e1;

    assign w_rise0 = r_sync0[SYNC_STAGES-1] & ~r_edge0;
    assign w_rise1 = r_sync1[SYNC_STAGES-1] & ~r_edge1;
    assign w_ei    = bus.EI      & bus.COMMIT;
    assign w_di    = bus.DI      & bus.COMMIT;
    assign w_reti  = bus.RETI    & bus.COMMIT;
    assign w_ack   = bus.INT_ACK & bus.COMMIT & r_int_req;

    // Eligibility looks at the IE value this cycle's EI/DI will leave behind,
    // so a committing DI withdraws an INT1 request on the very next edge.
    always_comb begin
        w_ie_next = r_ie;
        if (w_di)
            w_ie_next = 1'b0;
        else if (w_ei)
            w_ie_next = 1'b1;
    end

    assign w_e0 = r_pend0;
    assign w_e1 = r_pend1 & w_ie_next;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_sync0      <= '0;
            r_sync1      <= '0;
            r_edge0      <= 1'b0;
            r_edge1      <= 1'b0;
            r_pend0      <= 1'b0;
            r_pend1      <= 1'b0;
            r_ie         <= 1'b0;
            r_ie_saved   <= 1'b0;
            r_int_req    <= 1'b0;
            r_sel1       <= 1'b0;
            r_vector     <= 16'h0000;
            r_in_service <= 2'b00;
        end else begin
            r_sync0 <= {r_sync0[SYNC_STAGES-2:0], bus.INT0};
            r_sync1 <= {r_sync1[SYNC_STAGES-2:0], bus.INT1};
            r_edge0 <= r_sync0[SYNC_STAGES-1];
            r_edge1 <= r_sync1[SYNC_STAGES-1];
            r_pend0 <= r_pend0 | w_rise0;
            r_pend1 <= r_pend1 | w_rise1;
            r_ie    <= w_ie_next;

            case (r_state)
                S_IDLE: begin
                    if (w_e0 | w_e1) begin
                        r_state   <= S_REQ;
                        r_int_req <= 1'b1;
                        r_sel1    <= ~w_e0;
                        r_vector  <= w_e0 ? VEC0 : VEC1;
                    end
                end
                S_REQ: begin
                    if (w_ack) begin
                        // A fresh edge on the taken line in this cycle keeps it pending.
                        if (r_sel1)
                            r_pend1 <= w_rise1;
                        else
                            r_pend0 <= w_rise0;
                        r_in_service <= r_sel1 ? 2'b10 : 2'b01;
                        r_ie_saved   <= r_ie;
                        r_ie         <= 1'b0;
                        r_int_req    <= 1'b0;
                        r_state      <= S_SERVICE;
                    end else if (w_e0 | w_e1) begin
                        r_sel1   <= ~w_e0;
                        r_vector <= w_e0 ? VEC0 : VEC1;
                    end else begin
                        r_int_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_SERVICE: begin
                    if (w_reti) begin
                        r_in_service <= 2'b00;
                        r_ie         <= r_ie_saved;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_int_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.INT_REQ    = r_int_req;
    assign bus.VECTOR     = r_vector;
    assign bus.IE         = r_ie;
    assign bus.IN_SERVICE = r_in_service;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: hand-computed expectations for
// latency, priority, masking, withdrawal, service nesting and reset.
module tb_interrupt_controller;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   failures = 0;

    interrupt_controller_if intf();

    interrupt_controller #(
        .VEC0        (16'h0004),
        .VEC1        (16'h0008),
        .SYNC_STAGES (2)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (intf)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cmt(input logic ei, input logic di, input logic reti, input logic ack);
        intf.COMMIT  = 1'b1;
        intf.EI      = ei;
        intf.DI      = di;
        intf.RETI    = reti;
        intf.INT_ACK = ack;
        tick();
        intf.COMMIT  = 1'b0;
        intf.EI      = 1'b0;
        intf.DI      = 1'b0;
        intf.RETI    = 1'b0;
        intf.INT_ACK = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [15:0] vec,
                           input logic ie, input logic [1:0] isv);
        chk({tag, ".req"}, {31'd0, intf.INT_REQ}, {31'd0, req});
        chk({tag, ".vec"}, {16'd0, intf.VECTOR}, {16'd0, vec});
        chk({tag, ".ie"},  {31'd0, intf.IE}, {31'd0, ie});
        chk({tag, ".isv"}, {30'd0, intf.IN_SERVICE}, {30'd0, isv});
    endtask

    // One-cycle pin pulse; leaves the clock just after the edge that sampled it.
    task automatic pulse0();
        intf.INT0 = 1'b1;
        tick();
        intf.INT0 = 1'b0;
    endtask

    task automatic pulse1();
        intf.INT1 = 1'b1;
        tick();
        intf.INT1 = 1'b0;
    endtask

    initial begin
        intf.INT0 = 0; intf.INT1 = 0; intf.COMMIT = 0; intf.EI = 0;
        intf.DI = 0; intf.RETI = 0; intf.INT_ACK = 0;
        ticks(2);
        RESET = 1'b0;
        chk_out("reset", 1'b0, 16'h0000, 1'b0, 2'b00);

        // INT0 latency: request appears four edges after the pin is sampled.
        pulse0();
        ticks(2);
        chk("t1.lat3", {31'd0, intf.INT_REQ}, 32'd0);
        tick();
        chk_out("t1.req", 1'b1, 16'h0004, 1'b0, 2'b00);
        intf.INT_ACK = 1'b1;               // ack without COMMIT is ignored
        tick();
        intf.INT_ACK = 1'b0;
        chk("t1.noack", {31'd0, intf.INT_REQ}, 32'd1);
        cmt(0, 0, 0, 1);
        chk_out("t1.ack", 1'b0, 16'h0004, 1'b0, 2'b01);
        cmt(0, 0, 1, 0);
        chk_out("t1.reti", 1'b0, 16'h0004, 1'b0, 2'b00);
        ticks(2);
        chk("t1.idle", {31'd0, intf.INT_REQ}, 32'd0);

        // INT1 held high while masked, then unmasked by EI.
        intf.INT1 = 1'b1;
        ticks(4);
        cmt(0, 0, 0, 0);
        cmt(0, 0, 0, 0);
        cmt(0, 0, 0, 0);
        chk("t2.masked", {31'd0, intf.INT_REQ}, 32'd0);
        intf.EI = 1'b1;                    // EI without COMMIT is ignored
        tick();
        intf.EI = 1'b0;
        chk("t2.ei_nocommit", {31'd0, intf.IE}, 32'd0);
        cmt(1, 0, 0, 0);
        chk_out("t2.req", 1'b1, 16'h0008, 1'b1, 2'b00);
        cmt(0, 0, 0, 1);
        chk_out("t2.ack", 1'b0, 16'h0008, 1'b0, 2'b10);
        cmt(0, 0, 1, 0);
        chk_out("t2.reti", 1'b0, 16'h0008, 1'b1, 2'b00);
        ticks(3);
        chk("t2.level_once", {31'd0, intf.INT_REQ}, 32'd0);
        intf.INT1 = 1'b0;
        ticks(3);

        // INT1 requested, then INT0 arrives and takes over the vector.
        pulse1();
        ticks(3);
        chk_out("t3.req1", 1'b1, 16'h0008, 1'b1, 2'b00);
        pulse0();
        ticks(2);
        chk("t3.vec_still1", {16'd0, intf.VECTOR}, 32'h0008);
        tick();
        chk_out("t3.vec0", 1'b1, 16'h0004, 1'b1, 2'b00);
        cmt(0, 0, 0, 1);
        chk_out("t3.ack0", 1'b0, 16'h0004, 1'b0, 2'b01);
        cmt(0, 0, 1, 0);
        chk_out("t3.reti", 1'b0, 16'h0004, 1'b1, 2'b00);
        tick();
        chk_out("t3.rereq1", 1'b1, 16'h0008, 1'b1, 2'b00);
        cmt(0, 0, 0, 1);
        chk("t3.ack1", {30'd0, intf.IN_SERVICE}, 32'h2);
        cmt(0, 0, 1, 0);
        chk("t3.reti1", {31'd0, intf.IE}, 32'd1);

        // INT1 edge during INT0 service waits for RETI.
        pulse0();
        ticks(3);
        cmt(0, 0, 0, 1);
        chk_out("t4.svc0", 1'b0, 16'h0004, 1'b0, 2'b01);
        pulse1();
        ticks(5);
        chk("t4.held", {31'd0, intf.INT_REQ}, 32'd0);
        cmt(0, 0, 1, 0);
        chk_out("t4.reti", 1'b0, 16'h0004, 1'b1, 2'b00);
        tick();
        chk_out("t4.req1", 1'b1, 16'h0008, 1'b1, 2'b00);
        cmt(0, 0, 0, 1);
        cmt(0, 0, 1, 0);
        chk("t4.done", {30'd0, intf.IN_SERVICE}, 32'd0);

        // DI withdraws an INT1 request; the pending flag survives for EI.
        pulse1();
        ticks(3);
        chk("t5.req", {31'd0, intf.INT_REQ}, 32'd1);
        cmt(0, 1, 0, 0);
        chk_out("t5.withdraw", 1'b0, 16'h0008, 1'b0, 2'b00);
        ticks(3);
        chk("t5.stay_off", {31'd0, intf.INT_REQ}, 32'd0);
        cmt(1, 0, 0, 0);
        chk_out("t5.reappear", 1'b1, 16'h0008, 1'b1, 2'b00);
        cmt(0, 0, 0, 1);
        chk_out("t5.ack", 1'b0, 16'h0008, 1'b0, 2'b10);

        // Reset one cycle into service with IE=1 and an INT0 edge in flight.
        intf.INT0 = 1'b1;
        cmt(1, 0, 0, 0);
        intf.INT0 = 1'b0;
        chk("t6.ie_set", {31'd0, intf.IE}, 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk_out("t6.reset", 1'b0, 16'h0000, 1'b0, 2'b00);
        ticks(6);
        chk("t6.no_req", {31'd0, intf.INT_REQ}, 32'd0);

        // RETI outside service leaves IE alone; EI with DI clears IE.
        cmt(1, 0, 0, 0);
        cmt(0, 0, 1, 0);
        chk("misc.reti_idle", {31'd0, intf.IE}, 32'd1);
        cmt(1, 1, 0, 0);
        chk("misc.ei_di", {31'd0, intf.IE}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sequences interrupt entry and exit for the processor core.
- Synchronises the raw INT0/INT1 pins and latches rising edges as pending requests.
- Prioritises and masks pending requests, then requests the core to vector at an instruction boundary.
- Tracks the in-service level until RETI, owning the interrupt-enable flag that EI/DI/RETI manipulate.
- INT0 is non-maskable (vector 0x0004); INT1 is maskable (vector 0x0008).

Parameters:
- VEC0, 16'h0004, INT0 handler address.
- VEC1, 16'h0008, INT1 handler address.
- SYNC_STAGES, 2, synchroniser flops per interrupt pin (minimum 2).

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- INT0  in  1  raw asynchronous non-maskable interrupt pin.
- INT1  in  1  raw asynchronous maskable interrupt pin.
- COMMIT  in  1  core phase strobe, high in the last cycle of each instruction.
- EI  in  1  EI instruction executing; qualified by COMMIT.
- DI  in  1  DI instruction executing; qualified by COMMIT.
- RETI  in  1  RETI instruction executing; qualified by COMMIT.
- INT_ACK  in  1  core accepts the request; only valid while COMMIT=1 and INT_REQ=1.
- INT_REQ  out  1  request to vector at the next instruction boundary.
- VECTOR  out  16  handler address; valid while INT_REQ=1.
- IE  out  1  interrupt-enable flag.
- IN_SERVICE  out  2  bit0 = INT0 handler active, bit1 = INT1 handler active.

Behaviour:
- Reset values, held from the cycle after RESET is sampled high:
  - INT_REQ=0, VECTOR=0, IE=0, IN_SERVICE=0.
  - Pending flags=0, IE_SAVED=0, synchronisers=0, state=IDLE.
- Input path:
  - Each pin passes through SYNC_STAGES flops, then an edge register.
  - A rising edge on the synchronised signal sets PEND0 or PEND1.
  - Pin-to-pending latency is SYNC_STAGES+1 cycles.
  - A level held high produces exactly one pending event.
- Eligibility:
  - E0 = PEND0.
  - E1 = PEND1 & IE.
  - Priority: INT0 over INT1.
- State machine:
  - IDLE: if (E0|E1), go to REQ next cycle. INT_REQ=1 and VECTOR=VEC0 if E0, else VEC1.
  - REQ, vector update: VECTOR re-evaluates every cycle. If PEND0 sets while INT1 is requested, VECTOR switches to VEC0.
  - REQ, withdrawal: if eligibility drops (DI&COMMIT with only PEND1 pending), return to IDLE. INT_REQ=0 next cycle.
  - REQ, acceptance: INT_ACK&COMMIT accepts the vector presented in that cycle. Next cycle:
    - clear the taken pending flag;
    - set the matching IN_SERVICE bit;
    - IE_SAVED<=IE, IE<=0;
    - INT_REQ=0; state=SERVICE.
  - SERVICE: no new requests are issued; single level, no nesting, so INT0 also waits.
  - SERVICE exit: RETI&COMMIT clears IN_SERVICE, sets IE<=IE_SAVED, and moves to IDLE. A still-pending eligible request may re-enter REQ on the following cycle.
- EI&COMMIT sets IE=1 and DI&COMMIT clears IE, in any state.
- A RETI in IDLE or REQ is ignored; IE is unchanged.
- EI, DI, RETI and INT_ACK without COMMIT are ignored.
- Simultaneous events:
  - A new edge on the same line in the ack cycle leaves the pending flag set; the new edge wins.
  - EI and DI together: DI wins.
  - INT_ACK while INT_REQ=0 is ignored.
- Edges arriving during SERVICE are latched and served after RETI.
- A second edge while already pending is lost; there is no counting.
- RESET mid-service or mid-request returns everything to the reset values. In-flight pending edges are discarded.

Test Plan:
- INT0 pulse, IE=0 → INT_REQ=1 and VECTOR=0x0004 four cycles after the pin. Ack at COMMIT → IN_SERVICE=01, INT_REQ=0, IE=0. RETI → IN_SERVICE=00, IE=0.
- INT1 held high with IE=0 across 3 instructions → INT_REQ stays 0. EI commits → INT_REQ=1 next cycle with VECTOR=0x0008. Ack → IN_SERVICE=10, IE=0. RETI → IE=1.
- INT1 requested with VECTOR=0x0008 unacked; INT0 edge arrives → VECTOR changes to 0x0004. Ack → IN_SERVICE=01. After RETI → INT1 re-requested with VECTOR=0x0008.
- INT1 edge during INT0 service → no INT_REQ until RETI. With IE_SAVED=1, INT_REQ=1 and VECTOR=0x0008 one cycle after RETI.
- INT1 requested, then DI commits before ack → INT_REQ=0 next cycle and PEND1 retained. EI later → request reappears.
- RESET asserted one cycle into SERVICE with IE=1 → IE=0, IN_SERVICE=00, INT_REQ=0, and no request after release.
